// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared types and default sizing for the FIFO write arbiter
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  localparam int DEF_WIDTH     = 8;
  localparam int DEF_NUM_REQ   = 4;
  localparam int DEF_BURST_MAX = 4;

endpackage

// File: rtl/fifo_rr_picker.sv
// rtl/fifo_rr_picker.sv - combinational round-robin winner select
module fifo_rr_picker
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     last_grant,
  output logic [IDW-1:0]     winner,
  output logic               any_req
);

  logic           found;
  logic [IDW-1:0] cand;

  // Scan starts just past last_grant so the previous holder is considered last.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    cand   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDW'((int'(last_grant) + k) % NUM_REQ);
      if (!found && req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter feeding one FIFO write port
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int NUM_REQ   = DEF_NUM_REQ,
  parameter int BURST_MAX = DEF_BURST_MAX,
  localparam int IDW      = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     w_enable,
  output logic [WIDTH-1:0]         w_data,
  input  logic                     w_ready,
  output logic [IDW-1:0]           grant_id,
  output logic                     busy
);

  localparam int CW = $clog2(BURST_MAX + 1);
  localparam logic [CW-1:0] BEAT_LAST = CW'(BURST_MAX - 1);

  arb_state_t     state, state_nxt;
  logic [IDW-1:0] grant_nxt;
  logic [CW-1:0]  beat_cnt, beat_cnt_nxt;
  logic [IDW-1:0] last_grant, last_grant_nxt;

  logic           holder_valid;
  logic           accepted;
  logic           rearb;
  logic [IDW-1:0] pick_base;
  logic [IDW-1:0] winner;
  logic           any_req;

  // While granted, rotation continues from the current holder so the next pick
  // is available in the same cycle the burst ends.
  assign pick_base = (state == GRANT) ? grant_id : last_grant;

  fifo_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_picker (
    .req        (req_valid),
    .last_grant (pick_base),
    .winner     (winner),
    .any_req    (any_req)
  );

  assign holder_valid = req_valid[grant_id];
  assign busy         = (state == GRANT);

  always_comb begin
    w_enable  = 1'b0;
    w_data    = '0;
    req_ready = '0;
    accepted  = 1'b0;
    if (state == GRANT) begin
      w_enable            = holder_valid;
      w_data              = req_data[int'(grant_id)*WIDTH +: WIDTH];
      accepted            = holder_valid && w_ready;
      req_ready[grant_id] = accepted;
    end
  end

  assign rearb = (accepted && (beat_cnt == BEAT_LAST)) || !holder_valid;

  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant_id;
    beat_cnt_nxt   = beat_cnt;
    last_grant_nxt = last_grant;
    case (state)
      IDLE: begin
        if (any_req) begin
          state_nxt    = GRANT;
          grant_nxt    = winner;
          beat_cnt_nxt = '0;
        end
      end
      GRANT: begin
        if (rearb) begin
          last_grant_nxt = grant_id;
          beat_cnt_nxt   = '0;
          if (any_req) begin
            state_nxt = GRANT;
            grant_nxt = winner;
          end else begin
            state_nxt = IDLE;
            grant_nxt = '0;
          end
        end else if (accepted) begin
          beat_cnt_nxt = beat_cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      grant_id   <= '0;
      beat_cnt   <= '0;
      last_grant <= IDW'(NUM_REQ - 1);
    end else begin
      state      <= state_nxt;
      grant_id   <= grant_nxt;
      beat_cnt   <= beat_cnt_nxt;
      last_grant <= last_grant_nxt;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - self-checking bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;

  localparam int W = 8;
  localparam int N = 4;
  localparam int B = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N*W-1:0] req_data = '0;
  logic [N-1:0]   req_ready;
  logic           w_enable;
  logic [W-1:0]   w_data;
  logic           w_ready = 1'b0;
  logic [1:0]     grant_id;
  logic           busy;

  fifo_wr_arbiter #(.WIDTH(W), .NUM_REQ(N), .BURST_MAX(B)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .w_enable  (w_enable),
    .w_data    (w_data),
    .w_ready   (w_ready),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model: holder < 0 means nobody owns the FIFO port.
  int holder = -1;
  int last = N - 1;
  int left = 0;
  int seq[N];
  int dcnt[N];
  logic [N-1:0] v = '0;
  logic [N-1:0] want = '0;
  logic [N-1:0] macc_now;
  int gq[$];

  logic       s_busy, s_we;
  logic [1:0] s_gid;
  logic [N-1:0] s_ready;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] dval(input int i, input int s);
    return W'(i * 64 + (s % 64));
  endfunction

  function automatic int pick(input logic [N-1:0] r, input int from);
    for (int k = 1; k <= N; k++)
      if (r[(from + k) % N]) return (from + k) % N;
    return -1;
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) req_data[i*W +: W] = dval(i, seq[i]);
    req_valid = v;
  endtask

  task automatic model_reset();
    holder = -1;
    last = N - 1;
    left = 0;
  endtask

  task automatic model_edge();
    logic a;
    macc_now = '0;
    if (!rst) begin
      model_reset();
    end else if (holder < 0) begin
      if (|v) begin
        holder = pick(v, last);
        left = B;
      end
    end else begin
      a = v[holder] && w_ready;
      if (a) begin
        left--;
        macc_now[holder] = 1'b1;
      end
      if ((a && left == 0) || !v[holder]) begin
        last = holder;
        holder = (|v) ? pick(v, holder) : -1;
        left = B;
      end
    end
    // Requesters hold valid until accepted, then follow want.
    for (int i = 0; i < N; i++) begin
      if (macc_now[i]) seq[i]++;
      if (!v[i] || macc_now[i]) v[i] = want[i];
    end
  endtask

  task automatic cycle();
    logic          e_we, e_busy;
    logic [W-1:0]  e_wd;
    logic [N-1:0]  e_rdy;
    logic [1:0]    e_gid;
    int            idx;
    drive();
    #1;
    if (holder < 0) begin
      e_we = 1'b0; e_wd = '0; e_rdy = '0; e_busy = 1'b0; e_gid = '0;
    end else begin
      e_we   = v[holder];
      e_wd   = dval(holder, seq[holder]);
      e_rdy  = (e_we && w_ready) ? N'(1 << holder) : '0;
      e_busy = 1'b1;
      e_gid  = 2'(holder);
    end
    chk("busy", 32'(busy), 32'(e_busy));
    chk("grant_id", 32'(grant_id), 32'(e_gid));
    chk("w_enable", 32'(w_enable), 32'(e_we));
    chk("w_data", 32'(w_data), 32'(e_wd));
    chk("req_ready", 32'(req_ready), 32'(e_rdy));
    s_busy = busy; s_gid = grant_id; s_ready = req_ready; s_we = w_enable;
    if (|req_ready) begin
      chk("ready_onehot", 32'($countones(req_ready)), 32'd1);
      idx = 0;
      for (int i = N - 1; i >= 0; i--) if (req_ready[i]) idx = i;
      chk("fifo_order", 32'(w_data), 32'(dval(idx, dcnt[idx])));
      dcnt[idx]++;
      gq.push_back(idx);
    end
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    want = '0;
    v = '0;
    w_ready = 1'b0;
    repeat (2) cycle();
    rst = 1'b1;
  endtask

  int n2, n1;
  logic seen;

  initial begin
    for (int i = 0; i < N; i++) begin seq[i] = 0; dcnt[i] = 0; end
    @(negedge clk);

    // Reset state and sole requester 0 with back-to-back bursts.
    do_reset();
    chk("reset_busy", 32'(s_busy), 32'd0);
    chk("reset_we", 32'(s_we), 32'd0);
    want = 4'b0001; v = 4'b0001; w_ready = 1'b1;
    cycle();
    chk("t1_first_idle_ready", 32'(s_ready), 32'd0);
    gq.delete();
    cycle();
    chk("t1_busy", 32'(s_busy), 32'd1);
    chk("t1_gid", 32'(s_gid), 32'd0);
    chk("t1_ready", 32'(s_ready), 32'b0001);
    repeat (7) cycle();
    chk("t1_beats", 32'(gq.size()), 32'd8);
    foreach (gq[k]) chk("t1_owner", 32'(gq[k]), 32'd0);

    // All four requesting: 4-beat bursts in order 0,1,2,3,0 with no gap.
    do_reset();
    want = 4'b1111; v = 4'b1111; w_ready = 1'b1;
    cycle();
    gq.delete();
    repeat (20) cycle();
    chk("t2_beats", 32'(gq.size()), 32'd20);
    for (int k = 0; k < gq.size(); k++) chk("t2_order", 32'(gq[k]), 32'((k / 4) % 4));
    if (gq.size() == 20) begin
      chk("t2_slot4", 32'(gq[4]), 32'd1);
      chk("t2_wrap", 32'(gq[16]), 32'd0);
    end

    // Requester 2 stalled by w_ready low mid-burst.
    do_reset();
    want = 4'b0100; v = 4'b0100; w_ready = 1'b1;
    cycle();
    gq.delete();
    cycle();
    chk("t3_first_beat", 32'(gq.size()), 32'd1);
    want[0] = 1'b1; v[0] = 1'b1;
    w_ready = 1'b0;
    repeat (5) cycle();
    chk("t3_stall_no_ready", 32'(gq.size()), 32'd1);
    w_ready = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      cycle();
      foreach (gq[k]) if (gq[k] != 2) seen = 1'b1;
    end
    chk("t3_switch", 32'(seen), 32'd1);
    n2 = 0;
    foreach (gq[k]) if (gq[k] == 2) n2++;
    chk("t3_burst", 32'(n2), 32'd4);
    chk("t3_next_owner", 32'(gq[gq.size()-1]), 32'd0);

    // Requester 1 drops after 2 beats while requester 3 waits.
    do_reset();
    want = 4'b1010; v = 4'b1010; w_ready = 1'b1;
    cycle();
    gq.delete();
    cycle();
    want[1] = 1'b0;
    cycle();
    cycle();
    chk("t4_gap_gid", 32'(s_gid), 32'd1);
    cycle();
    chk("t4_gid", 32'(s_gid), 32'd3);
    n1 = 0;
    foreach (gq[k]) if (gq[k] == 1) n1++;
    chk("t4_req1_beats", 32'(n1), 32'd2);

    // Reset asserted mid-burst of requester 2.
    do_reset();
    want = 4'b0100; v = 4'b0100; w_ready = 1'b1;
    repeat (3) cycle();
    drive();
    #3;
    rst = 1'b0;
    #1;
    chk("t5_we_async", 32'(w_enable), 32'd0);
    chk("t5_busy_async", 32'(busy), 32'd0);
    chk("t5_ready_async", 32'(req_ready), 32'd0);
    model_reset();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    cycle();
    rst = 1'b1;
    want = 4'b1111; v = 4'b1111;
    cycle();
    cycle();
    chk("t5_first_gid", 32'(s_gid), 32'd0);
    chk("t5_first_busy", 32'(s_busy), 32'd1);

    // Random traffic with scoreboard.
    do_reset();
    for (int c = 0; c < 10000; c++) begin
      want = N'($urandom);
      w_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    for (int i = 0; i < N; i++) chk("t6_count", 32'(dcnt[i]), 32'(seq[i]));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter WIDTH, default 8: data width of each requester and of the FIFO write port.
REQ-002 Parameter NUM_REQ, default 4: number of write requesters, range 2..8.
REQ-003 Parameter BURST_MAX, default 4: maximum consecutive accepted beats per grant, range 1..16.
REQ-004 Derived localparam IDW = $clog2(NUM_REQ): grant index width.
REQ-005 clk  input  1  single clock; every flop samples on its rising edge.
REQ-006 rst  input  1  reset, asynchronous assert, active-low.
REQ-007 req_valid  input  NUM_REQ  per-requester write request.
REQ-008 req_data  input  NUM_REQ*WIDTH  requester i data in bits [i*WIDTH +: WIDTH].
REQ-009 req_ready  output  NUM_REQ  per-requester beat-accepted strobe.
REQ-010 w_enable  output  1  FIFO write enable.
REQ-011 w_data  output  WIDTH  FIFO write data.
REQ-012 w_ready  input  1  FIFO can accept a write (not full).
REQ-013 grant_id  output  IDW  index of the current grant holder; 0 when idle.
REQ-014 busy  output  1  high while in GRANT.

Function
REQ-015 The FSM SHALL have two states: IDLE and GRANT.
REQ-016 A beat SHALL be accepted exactly when w_enable && w_ready are high at a rising clk.
REQ-017 In GRANT: w_enable = req_valid[grant_id], w_data = req_data slice grant_id, req_ready[grant_id] = w_enable && w_ready. All other req_ready bits SHALL be 0. In IDLE: w_enable = 0 and w_data = 0.
REQ-018 Round-robin pick: the winner SHALL be the first valid requester scanning last_grant+1, last_grant+2, ... modulo NUM_REQ, with last_grant itself checked last.
REQ-019 IDLE -> GRANT on the edge where any req_valid is high. grant_id SHALL take the pick result, beat_cnt SHALL be cleared, and the first beat SHALL be possible on the next cycle (1-cycle arbitration latency).
REQ-020 Each accepted beat SHALL increment beat_cnt. While w_ready is low, beat_cnt and grant_id SHALL hold (stall).
REQ-021 Re-arbitration SHALL occur at an edge where (accepted && beat_cnt == BURST_MAX-1) or req_valid[grant_id] == 0.
REQ-022 On re-arbitration, the FSM SHALL go to GRANT with the new pick if any req_valid is high, else to IDLE. last_grant SHALL be updated to the outgoing grant_id and beat_cnt cleared. There is no bubble cycle between grants.
REQ-023 When the sole valid requester ends its burst, it SHALL be re-granted immediately with beat_cnt = 0.
REQ-024 Requesters SHALL hold valid and data stable until ready. The arbiter SHALL NOT check this.
REQ-025 The arbiter SHALL never drop or duplicate a beat; FIFO beat order SHALL equal grant order.

Reset
REQ-026 On rst low, the following SHALL take effect asynchronously: state = IDLE, grant_id = 0, beat_cnt = 0, last_grant = NUM_REQ-1 (so requester 0 wins first), w_enable = 0, req_ready = 0, busy = 0.
REQ-027 Reset asserted mid-burst SHALL abort the burst with no further writes. Arbitration SHALL resume on the first clk edge after rst rises.

Structure
REQ-028 Package fifo_arb_pkg SHALL hold the state enum type (IDLE, GRANT) and the default WIDTH/NUM_REQ/BURST_MAX constants.
REQ-029 Round-robin selection SHALL live in combinational sub-module fifo_rr_picker (inputs: request vector, last_grant; outputs: winner index, any_req). All state SHALL reside in fifo_wr_arbiter.

Verification
REQ-030 Reset release, req_valid=4'b0001, w_ready=1 -> busy high next cycle, grant_id=0, beats accepted for 4 cycles, then re-grant of 0 (beat_cnt cleared).
REQ-031 req_valid=4'b1111 constant, w_ready=1, BURST_MAX=4 -> grants in order 0,1,2,3,0, each exactly 4 beats, no idle cycle between them.
REQ-032 Requester 2 granted, w_ready low for 5 cycles mid-burst -> no req_ready pulses during the stall, beat_cnt held, burst completes with exactly 4 total beats.
REQ-033 Requester 1 granted, drops req_valid after 2 beats while requester 3 is valid -> grant_id=3 on the next cycle; requester 1 has exactly 2 data beats in the FIFO.
REQ-034 rst pulsed low mid-burst of requester 2 -> w_enable=0 immediately; after release with 4'b1111, the first grant is 0.
REQ-035 Scoreboard over random valid/w_ready for 10k cycles -> per-requester FIFO data matches issue order; no beat is lost or duplicated.
